// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop byte-stream handshake plus the ram1k drive bundle of the FIFO controller.
// The master side is the requester together with the RAM. The slave side is the controller.
interface ram_fifo_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic          push;
    logic [DW-1:0] wr_data;
    logic          push_rdy;
    logic          pop;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ram_en;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        output push, wr_data, pop, ram_dout,
        input  push_rdy, pop_valid, pop_data, full, empty, count,
               ram_en, ram_rw, ram_addr, ram_din
    );

    modport slave (
        input  push, wr_data, pop, ram_dout,
        output push_rdy, pop_valid, pop_data, full, empty, count,
               ram_en, ram_rw, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 1K x 8 single-port RAM. Pop data arrives 1 cycle after the pop fires.
// Pop owns the RAM port, so a pop that fires holds off a push in the same cycle (push_rdy=0).
module ram_fifo_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_valid_q, pop_valid_d;
    logic          full, empty;
    logic          pop_fire, push_rdy, push_fire;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign pop_fire  = bus.pop && !empty && !rst;
    assign push_rdy  = !full && !pop_fire && !rst;
    assign push_fire = bus.push && push_rdy;

    assign bus.push_rdy  = push_rdy;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.pop_valid = pop_valid_q;
    // The RAM floats its output when idle, so gate it off outside a valid read.
    assign bus.pop_data  = pop_valid_q ? bus.ram_dout : '0;

    always_comb begin
        bus.ram_en   = 1'b0;
        bus.ram_rw   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (pop_fire) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = rd_ptr_q;
        end else if (push_fire) begin
            bus.ram_en   = 1'b1;
            bus.ram_rw   = 1'b1;
            bus.ram_addr = wr_ptr_q;
            bus.ram_din  = bus.wr_data;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_fire;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus random traffic checked against a queue model.
// The RAM model returns random bytes whenever it is not reading, standing in for a floating bus.
module tb_ram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_rw) begin
            mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout      <= DW'($urandom);
        end else if (bus.ram_en) begin
            bus.ram_dout <= mem[bus.ram_addr];
        end else begin
            bus.ram_dout <= DW'($urandom);
        end
    end

    // Reference model: contents in order, plus running totals of accepted pushes and pops.
    logic [DW-1:0] q[$];
    int            wr_tot;
    int            rd_tot;
    bit            exp_vld;
    logic [DW-1:0] exp_dat;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle(input bit p, input logic [DW-1:0] d, input bit o, input bit r);
        bit exp_pop_fire, exp_push_rdy, exp_push_fire;
        bus.push    = p;
        bus.wr_data = d;
        bus.pop     = o;
        rst         = r;
        #1;
        exp_pop_fire  = o && (q.size() != 0) && !r;
        exp_push_rdy  = (q.size() != DEPTH) && !exp_pop_fire && !r;
        exp_push_fire = p && exp_push_rdy;
        chk("push_rdy", 32'(bus.push_rdy), 32'(exp_push_rdy));
        chk("ram_en", 32'(bus.ram_en), 32'(exp_pop_fire || exp_push_fire));
        if (exp_pop_fire) begin
            chk("ram_rw_rd", 32'(bus.ram_rw), 32'(0));
            chk("ram_addr_rd", 32'(bus.ram_addr), 32'(rd_tot % DEPTH));
        end else if (exp_push_fire) begin
            chk("ram_rw_wr", 32'(bus.ram_rw), 32'(1));
            chk("ram_addr_wr", 32'(bus.ram_addr), 32'(wr_tot % DEPTH));
            chk("ram_din", 32'(bus.ram_din), 32'(d));
        end else begin
            chk("ram_idle", {bus.ram_rw, bus.ram_addr, bus.ram_din}, 32'(0));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            wr_tot  = 0;
            rd_tot  = 0;
            exp_vld = 1'b0;
        end else begin
            exp_vld = exp_pop_fire;
            if (exp_pop_fire) begin
                exp_dat = q.pop_front();
                rd_tot++;
            end
            if (exp_push_fire) begin
                q.push_back(d);
                wr_tot++;
            end
        end
        @(negedge clk);
        chk("pop_valid", 32'(bus.pop_valid), 32'(exp_vld));
        chk("pop_data", 32'(bus.pop_data), exp_vld ? 32'(exp_dat) : 32'(0));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    endtask

    task automatic do_reset();
        cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.wr_data = '0;
        bus.pop     = 1'b0;
        rst         = 1'b1;
        wr_tot      = 0;
        rd_tot      = 0;
        exp_vld     = 1'b0;
        exp_dat     = '0;

        // Ordered push/pop of three bytes
        do_reset();
        cycle(1, 8'd12, 0, 0);
        cycle(1, 8'd32, 0, 0);
        cycle(1, 8'd121, 0, 0);
        repeat (4) cycle(0, 8'h00, 1, 0);

        // Fill to full, extra push refused, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0, 0);
        cycle(1, 8'hEE, 0, 0);
        cycle(1, 8'hEF, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

        // Push and pop together with count=3: pop wins, held push lands next cycle
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'h40 + i), 0, 0);
        cycle(1, 8'hAA, 1, 0);
        cycle(1, 8'hAA, 0, 0);
        repeat (4) cycle(0, 8'h00, 1, 0);

        // Push and pop together while empty: push served
        cycle(1, 8'h77, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Alternating push/pop long enough for both pointers to wrap
        do_reset();
        for (int i = 0; i < 1030; i++) begin
            cycle(1, DW'($urandom), 0, 0);
            cycle(0, 8'h00, 1, 0);
        end
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h3C, 0, 0);
        cycle(0, 8'h00, 1, 0);

        // Pop on empty
        repeat (3) cycle(0, 8'h00, 1, 0);

        // Reset while a read is in flight
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, DW'(8'h90 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        // Random traffic with shifting push bias and rare resets
        for (int i = 0; i < 3000; i++) begin
            int  bias;
            bit  rp, ro, rr;
            bias = (i < 1500) ? 70 : 35;
            rp   = ($urandom_range(0, 99) < bias);
            ro   = ($urandom_range(0, 99) < 50);
            rr   = ($urandom_range(0, 499) == 0);
            cycle(rp, DW'($urandom), ro, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
